// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               FSM states, next-PC selector, default widths and the
//               saturating retired-fetch counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned A_DEF = 10;
  localparam int unsigned W_DEF = 9;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_SEQ  = 3'd1,
    PC_ABS  = 3'd2,
    PC_REL  = 3'd3,
    PC_LOAD = 3'd4
  } pc_sel_e;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle between the fetch stage and its environment (control
//               from decode, ROM address/data, instruction register out).
//               slave = fetch stage side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int A = A_DEF,
  parameter int W = W_DEF
);
  logic             Start;
  logic [A-1:0]     StartAddr;
  logic             Stall;
  logic             BranchTaken;
  logic             BranchRel;
  logic [A-1:0]     Target;
  logic             Halt;
  logic [A-1:0]     InstAddress;
  logic [W-1:0]     InstIn;
  logic [W-1:0]     InstOut;
  logic             InstValid;
  logic             Done;
  logic [CNT_W-1:0] InstCount;

  modport slave (
    input  Start, StartAddr, Stall, BranchTaken, BranchRel, Target, Halt, InstIn,
    output InstAddress, InstOut, InstValid, Done, InstCount
  );

  modport master (
    output Start, StartAddr, Stall, BranchTaken, BranchRel, Target, Halt, InstIn,
    input  InstAddress, InstOut, InstValid, Done, InstCount
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : PC register with next-PC mux (hold, sequential, absolute,
//               PC-relative, load). All arithmetic is modulo 2**A.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
  import fetch_pkg::*;
#(
  parameter int A = A_DEF
) (
  input  wire logic         CLK,
  input  wire logic         Reset_n,
  input  wire pc_sel_e      sel,
  input  wire logic [A-1:0] load_addr,
  input  wire logic [A-1:0] target,
  output logic      [A-1:0] pc
);

  logic [A-1:0] pc_q;
  logic [A-1:0] pc_d;

  // Next-PC select; the relative form is anchored on the branch's own
  // address (PC-1) and an A-bit add is the same as sign-extending the offset
  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_HOLD: pc_d = pc_q;
      PC_SEQ:  pc_d = pc_q + A'(1);
      PC_ABS:  pc_d = target;
      PC_REL:  pc_d = pc_q - A'(1) + target;
      PC_LOAD: pc_d = load_addr;
      default: pc_d = pc_q;
    endcase
  end

  // PC register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) pc_q <= '0;
    else          pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC (drives the ROM address),
//               registers the ROM word for decode, handles start / halt /
//               stall / branch redirect and counts retired fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int A = A_DEF,
  parameter int W = W_DEF
) (
  input  wire logic   CLK,
  input  wire logic   Reset_n,
  fetch_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [W-1:0]     inst_q,  inst_d;
  logic             valid_q, valid_d;
  logic             done_q,  done_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  pc_sel_e          pc_sel;
  logic [A-1:0]     pc;

  program_counter #(.A(A)) u_pc (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .sel       (pc_sel),
    .load_addr (bus.StartAddr),
    .target    (bus.Target),
    .pc        (pc)
  );

  // Next-state logic; in RUN the order is Halt > Stall > Branch > sequential,
  // and Halt/Branch only act on a live instruction
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    pc_sel  = PC_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          pc_sel  = PC_LOAD;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (valid_q && !bus.Stall && !bus.Halt) cnt_d = sat_inc(cnt_q);
        if (bus.Halt && valid_q) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
          valid_d = 1'b0;
        end else if (bus.Stall) begin
          pc_sel = PC_HOLD;
        end else if (bus.BranchTaken && valid_q) begin
          pc_sel  = bus.BranchRel ? PC_REL : PC_ABS;
          inst_d  = bus.InstIn;
          valid_d = 1'b0;       // fall-through word is squashed
        end else begin
          pc_sel  = PC_SEQ;
          inst_d  = bus.InstIn;
          valid_d = 1'b1;
        end
      end
      ST_HALTED: begin
        if (bus.Start) begin
          pc_sel  = PC_LOAD;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, instruction register, valid, done and counter registers
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      inst_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.InstAddress = pc;
  assign bus.InstOut     = inst_q;
  assign bus.InstValid   = valid_q;
  assign bus.Done        = done_q;
  assign bus.InstCount   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed scenarios then
//               randomized control, compared against a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int A     = 10;
  localparam int W     = 9;
  localparam int DEPTH = 1 << A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if #(.A(A), .W(W)) bus ();

  fetch_unit #(.A(A), .W(W)) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  logic [W-1:0] rom [DEPTH];
  assign bus.InstIn = rom[bus.InstAddress];

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain integers, updated once per rising edge
  bit m_running, m_halted;
  int m_pc, m_out, m_cnt;
  bit m_valid, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int wrap(input int x);
    return ((x % DEPTH) + DEPTH) % DEPTH;
  endfunction

  task automatic model_reset();
    m_running = 0; m_halted = 0;
    m_pc = 0; m_out = 0; m_cnt = 0; m_valid = 0; m_done = 0;
  endtask

  task automatic model_edge();
    logic signed [A-1:0] t_s;
    int word;
    t_s  = bus.Target;
    word = int'(rom[m_pc]);
    if (!m_running) begin
      if (bus.Start) begin
        m_pc = int'(bus.StartAddr);
        m_cnt = 0; m_done = 0;
        m_running = 1; m_halted = 0;
      end
    end else begin
      if (m_valid && !bus.Stall && !bus.Halt && m_cnt < 65535) m_cnt++;
      if (bus.Halt && m_valid) begin
        m_running = 0; m_halted = 1; m_done = 1; m_valid = 0;
      end else if (bus.Stall) begin
        // everything holds
      end else if (bus.BranchTaken && m_valid) begin
        m_pc    = bus.BranchRel ? wrap(m_pc - 1 + int'(t_s)) : int'(bus.Target);
        m_out   = word;
        m_valid = 0;
      end else begin
        m_out   = word;
        m_valid = 1;
        m_pc    = wrap(m_pc + 1);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  32'(bus.InstAddress), 32'(m_pc));
    chk({tag, ".out"},   32'(bus.InstOut),     32'(m_out));
    chk({tag, ".valid"}, 32'(bus.InstValid),   32'(m_valid));
    chk({tag, ".done"},  32'(bus.Done),        32'(m_done));
    chk({tag, ".cnt"},   32'(bus.InstCount),   32'(m_cnt));
  endtask

  // Advance one clock with the currently driven inputs and compare
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.Start = 0; bus.StartAddr = '0; bus.Stall = 0; bus.BranchTaken = 0;
    bus.BranchRel = 0; bus.Target = '0; bus.Halt = 0;
  endtask

  // Asynchronous reset pulse placed between edges
  task automatic mid_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk({tag, ".addr"},  32'(bus.InstAddress), 32'd0);
    chk({tag, ".valid"}, 32'(bus.InstValid),   32'd0);
    chk({tag, ".done"},  32'(bus.Done),        32'd0);
    chk({tag, ".cnt"},   32'(bus.InstCount),   32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = W'($urandom);
    for (int i = 5; i <= 8; i++) rom[i] = W'(9'h100 + i);
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset");

    // Sequential fetch from 5
    bus.Start = 1; bus.StartAddr = 10'd5;
    step("start5");
    chk("start5.pc", 32'(bus.InstAddress), 32'd5);
    bus.Start = 0;
    step("seq5");
    chk("seq.w5", 32'(bus.InstOut), 32'(rom[5]));
    step("seq6");
    chk("seq.w6", 32'(bus.InstOut), 32'(rom[6]));

    // Absolute branch at PC=7 to 20
    bus.BranchTaken = 1; bus.BranchRel = 0; bus.Target = 10'd20;
    step("babs");
    chk("babs.bubble", 32'(bus.InstValid), 32'd0);
    bus.BranchTaken = 0;
    step("babs2");
    chk("babs.w20", 32'(bus.InstOut), 32'(rom[20]));

    // Go to 10, then relative -3 from the word at 10
    bus.BranchTaken = 1; bus.Target = 10'd10;
    step("to10");
    bus.BranchTaken = 0;
    step("at10");
    bus.BranchTaken = 1; bus.BranchRel = 1; bus.Target = 10'h3FD;
    step("brel");
    bus.BranchTaken = 0; bus.BranchRel = 0;
    step("brel2");
    chk("brel.w7", 32'(bus.InstOut), 32'(rom[7]));

    // Start while running is ignored
    bus.Start = 1; bus.StartAddr = 10'd100;
    step("start_in_run");
    bus.Start = 0;

    // Halt, then PC frozen
    bus.Halt = 1;
    step("halt");
    chk("halt.done", 32'(bus.Done), 32'd1);
    bus.Halt = 0;
    step("halted");

    // Restart at 1023 with stall across the wrap
    bus.Start = 1; bus.StartAddr = 10'd1023;
    step("restart");
    bus.Start = 0;
    step("wrap1");
    chk("wrap.pc", 32'(bus.InstAddress), 32'd0);
    step("wrap2");
    bus.Stall = 1;
    repeat (3) step("stall");
    bus.Stall = 0;
    repeat (2) step("unstall");

    // Halt + branch + stall together: halt wins
    bus.Halt = 1; bus.BranchTaken = 1; bus.Stall = 1; bus.Target = 10'd300;
    step("combo");
    idle_inputs();
    step("combo2");

    // Restart at 0
    bus.Start = 1; bus.StartAddr = 10'd0;
    step("rs0");
    bus.Start = 0;
    step("rs0b");
    chk("rs0.w0", 32'(bus.InstOut), 32'(rom[0]));
    repeat (3) step("run");

    // Reset in the middle of RUN
    mid_reset("mreset");

    // Randomized control
    for (int c = 0; c < 3000; c++) begin
      bus.Start       = ($urandom_range(0, 29) == 0);
      bus.StartAddr   = A'($urandom);
      bus.Stall       = ($urandom_range(0, 4) == 0);
      bus.BranchTaken = ($urandom_range(0, 5) == 0);
      bus.BranchRel   = 1'($urandom);
      bus.Target      = A'($urandom);
      bus.Halt        = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) mid_reset("rnd_reset");
      else step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction ROM. It owns the program counter and drives the ROM address. It registers the returned instruction word into an instruction register for the decode stage. It also handles start, halt, stall and branch redirection, and counts retired fetches.

## Interface
- A, 10, instruction address width (ROM depth 2**A)
- W, 9, instruction word width
- CLK  input  1  sole clock, all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  single-cycle request to begin execution at StartAddr
- StartAddr  input  A  first instruction address
- Stall  input  1  downstream hold; freezes PC and instruction register
- BranchTaken  input  1  redirect request from decode, qualified by InstValid
- BranchRel  input  1  1: Target is signed PC-relative offset; 0: Target is absolute
- Target  input  A  branch target or offset
- Halt  input  1  decode has recognised a halt in the instruction register
- InstAddress  output  A  ROM address; equals PC register
- InstIn  input  W  ROM data, combinational function of InstAddress
- InstOut  output  W  instruction register to decode
- InstValid  output  1  InstOut holds a live instruction
- Done  output  1  program halted
- InstCount  output  16  count of instructions delivered

## Operation
- States: IDLE, RUN, HALTED.
- Reset values: state IDLE, PC 0, InstOut 0, InstValid 0, Done 0, InstCount 0.
- IDLE:
  - Start=1 loads PC with StartAddr, clears InstCount and enters RUN.
  - All other inputs are ignored.
- RUN: per-edge priority is Halt > Stall > BranchTaken > sequential.
  - Halt=1 (with InstValid=1): enter HALTED, Done←1, InstValid←0, PC holds.
  - Stall=1: PC, InstOut, InstValid and InstCount all hold. BranchTaken is ignored; decode keeps it asserted until the stall ends.
  - BranchTaken=1 (with InstValid=1):
    - PC←Target when BranchRel=0.
    - PC←(PC−1)+sext(Target) when BranchRel=1, i.e. relative to the branch's own address.
    - InstOut←InstIn, but InstValid←0 (the fall-through word is squashed).
  - Sequential: InstOut←InstIn, InstValid←1, PC←PC+1.
- Wrap-around: all PC arithmetic is modulo 2**A, so PC=2**A−1 increments to 0.
- InstCount increments on each RUN edge where InstValid=1, Stall=0 and Halt=0. It saturates at 16'hFFFF.
- Start in RUN is ignored.
- HALTED:
  - Done stays 1 and PC holds.
  - Start=1 reloads PC with StartAddr, clears Done and InstCount, and enters RUN.
- Reset_n low at any time forces the reset values immediately, independent of CLK.

## Timing
- InstAddress is a register output; ROM read is combinational, so InstIn is valid in the same cycle.
- Start sampled at edge k:
  - InstAddress=StartAddr after edge k.
  - InstOut=ROM[StartAddr] with InstValid=1 after edge k+1.
- Steady-state throughput: one instruction per cycle.
- Taken branch costs exactly one bubble (one cycle with InstValid=0).
- Halt sampled at edge k: Done=1 after edge k. No further instruction becomes valid.
- Stall adds zero-latency hold; outputs resume on the first edge with Stall=0.
- Reset deassertion is synchronised externally; the block assumes a clean release.

## Structure
- Package fetch_pkg holds:
  - the state enum (IDLE, RUN, HALTED) and default widths A=10, W=9;
  - the InstCount width 16 and its saturation constant.
- Sub-module program_counter contains the PC register and next-PC mux (sequential, absolute, relative, load, hold) with the wrap rule.
- fetch_unit holds the FSM, instruction register, valid bit and counter.
- The ROM is instantiated alongside fetch_unit, not inside it.

## Test plan
- Reset mid-RUN: assert Reset_n=0 between edges → InstAddress=0, InstValid=0, Done=0, InstCount=0 before the next edge.
- Sequential fetch: ROM[5..8]=distinct words, Start with StartAddr=5 → InstOut shows words 5,6,7,8 on consecutive cycles; InstCount=4 after the fourth valid edge.
- Branches:
  - Absolute: Target=20 at PC=7 → one InstValid=0 cycle, then InstOut=ROM[20].
  - Relative: Target=−3, with the branch word fetched from address 10 → next valid word is ROM[7].
- Stall plus wrap: StartAddr=1023, Stall high for 3 cycles mid-stream → InstOut and InstCount frozen for 3 cycles; PC wraps 1023→0.
- Halt and restart: Halt asserted with InstValid=1 → Done=1 next cycle and PC frozen. Start with StartAddr=0 → Done=0, InstCount=0, ROM[0] valid two edges later.
- Simultaneous events:
  - Halt+BranchTaken+Stall in one cycle → HALTED taken, branch and stall ignored.
  - Start while in RUN → no effect.
